// File: rtl/bnn_acc_cfu.sv
// Binary-NN accumulate CFU: XNOR-popcount MAC into a signed saturating accumulator.
// One byte of the XNOR vector is counted per cycle, so a MAC takes CFU_DATA_W/8 cycles.
module bnn_acc_cfu #(
  parameter logic [15:0] CFU_LI_VERSION = 16'h01_00,
  parameter int          CFU_N_CFUS     = 1,
  parameter int          CFU_CFU_ID_W   = 0,
  parameter int          CFU_FUNC_ID_W  = 2,
  parameter int          CFU_DATA_W     = 32,
  parameter int          ACC_W          = 16,
  localparam int         CFU_STATUS_W   = 3,
  localparam int         CFU_ID_PW      = (CFU_CFU_ID_W > 0) ? CFU_CFU_ID_W : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_en,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [CFU_ID_PW-1:0]     req_cfu,
  input  logic [CFU_FUNC_ID_W-1:0] req_func,
  input  logic [CFU_DATA_W-1:0]    req_data0,
  input  logic [CFU_DATA_W-1:0]    req_data1,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [CFU_STATUS_W-1:0]  resp_status,
  output logic [CFU_DATA_W-1:0]    resp_data
);

  localparam int N     = CFU_DATA_W / 8;
  localparam int IDX_W = $clog2(N);
  localparam int PC_W  = $clog2(CFU_DATA_W) + 1;
  localparam int SUM_W = CFU_DATA_W + 2;
  localparam logic [CFU_STATUS_W-1:0] CFU_OK = '0;
  localparam logic [CFU_FUNC_ID_W-1:0] FN_CLEAR = CFU_FUNC_ID_W'(0);
  localparam logic [CFU_FUNC_ID_W-1:0] FN_MAC   = CFU_FUNC_ID_W'(1);
  localparam logic [CFU_FUNC_ID_W-1:0] FN_SIGN  = CFU_FUNC_ID_W'(3);
  localparam logic signed [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] ACC_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  if (CFU_LI_VERSION != 16'h01_00 || CFU_N_CFUS != 1 ||
      (CFU_DATA_W != 32 && CFU_DATA_W != 64) || ACC_W < 2 || ACC_W > CFU_DATA_W) begin : check_cfu_l2_params
    $error("bnn_acc_cfu: unsupported parameter set");
  end

  typedef enum logic [1:0] {IDLE, COUNT, RESP} state_t;
  state_t state, state_nx;

  logic signed [ACC_W-1:0]      acc, acc_sat;
  logic [CFU_DATA_W-1:0]        vec;
  logic [IDX_W-1:0]             cnt;
  logic [PC_W-1:0]              pcnt, total;
  logic [3:0]                   byte_pc;
  logic signed [SUM_W-1:0]      sum;
  logic [CFU_DATA_W-1:0]        acc_out, sat_out;
  logic                         accept, last, hs, sign_ge;
  logic                         unused_ok;

  assign req_ready   = (state == IDLE) && !rst;
  assign accept      = clk_en && req_valid && req_ready;
  assign last        = (cnt == IDX_W'(N - 1));
  assign hs          = clk_en && resp_valid && resp_ready;
  assign resp_status = CFU_OK;
  assign unused_ok   = ^req_cfu;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (req_func == FN_MAC) ? COUNT : RESP;
      COUNT:   if (clk_en && last) state_nx = RESP;
      RESP:    if (hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // The XNOR vector is shifted down a byte per COUNT cycle, so byte 0 is always the current one.
  always_comb begin
    byte_pc = '0;
    for (int i = 0; i < 8; i++) byte_pc = byte_pc + 4'(vec[i]);
  end

  assign total   = pcnt + PC_W'(byte_pc);
  assign sum     = SUM_W'(acc) + SUM_W'({total, 1'b0}) - SUM_W'(CFU_DATA_W);
  assign sign_ge = acc >= $signed(req_data0[ACC_W-1:0]);
  assign acc_out = CFU_DATA_W'(acc);
  assign sat_out = CFU_DATA_W'(acc_sat);

  always_comb begin
    if (sum > ACC_MAX)      acc_sat = ACC_MAX[ACC_W-1:0];
    else if (sum < ACC_MIN) acc_sat = ACC_MIN[ACC_W-1:0];
    else                    acc_sat = sum[ACC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      vec        <= '0;
      cnt        <= '0;
      pcnt       <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else if (clk_en) begin
      case (state)
        IDLE: if (accept) begin
          vec  <= ~(req_data0 ^ req_data1);
          cnt  <= '0;
          pcnt <= '0;
          if (req_func != FN_MAC) resp_valid <= 1'b1;
          if (req_func == FN_CLEAR) begin
            acc       <= '0;
            resp_data <= '0;
          end else if (req_func == FN_SIGN) begin
            acc       <= '0;
            resp_data <= CFU_DATA_W'(sign_ge);
          end else if (req_func != FN_MAC) begin
            resp_data <= acc_out;
          end
        end
        COUNT: begin
          pcnt <= total;
          cnt  <= cnt + 1'b1;
          vec  <= vec >> 8;
          if (last) begin
            acc        <= acc_sat;
            resp_data  <= sat_out;
            resp_valid <= 1'b1;
          end
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          resp_data  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_acc_cfu.sv
// Self-checking bench for bnn_acc_cfu: table-driven ops, saturation runs and handshake/reset corners.
module tb_bnn_acc_cfu;
  logic        clk = 1'b0, rst = 1'b1, clk_en = 1'b1;
  logic        req_valid = 1'b0, req_ready, resp_valid, resp_ready = 1'b1;
  logic [0:0]  req_cfu = '0;
  logic [1:0]  req_func = '0;
  logic [31:0] req_data0 = '0, req_data1 = '0, resp_data;
  logic [2:0]  resp_status;

  localparam logic [1:0] CLR = 2'd0, MAC = 2'd1, RD = 2'd2, SGN = 2'd3;

  bnn_acc_cfu dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .req_valid(req_valid), .req_ready(req_ready),
    .req_cfu(req_cfu), .req_func(req_func), .req_data0(req_data0), .req_data1(req_data1),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_status(resp_status),
    .resp_data(resp_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0, t_acc = 0, acc_m = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [1:0]  f;
    logic [31:0] a, b, exp;
    int          lat;
  } vec_t;
  vec_t tbl[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: every completed response handshake consumes one expected value.
  always @(negedge clk) begin
    if (!rst && clk_en && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_resp: got 0x%08h want none", resp_data);
      end else begin
        check("resp_data", resp_data, exp_q.pop_front());
        check("resp_status", 32'(resp_status), 32'd0);
      end
    end
  end

  function automatic int mac_m(input int acc, input logic [31:0] a, input logic [31:0] b);
    int s;
    s = acc + 2 * $countones(~(a ^ b)) - 32;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] exp);
    @(negedge clk);
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_func = f; req_data0 = a; req_data1 = b;
    if (push) exp_q.push_back(exp);
    @(posedge clk); #1;
    t_acc = cyc;
    req_valid = 1'b0;
    req_func  = 2'($urandom);
    req_data0 = $urandom;
    req_data1 = $urandom;
  endtask

  task automatic wait_resp(input int lat, input string name);
    do @(negedge clk); while (resp_valid !== 1'b1 && cyc - t_acc < 100);
    check(name, 32'(cyc - t_acc + 1), 32'(lat));
    if (resp_ready) @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] exp, input int lat, input string name);
    issue(f, a, b, 1'b1, exp);
    wait_resp(lat, name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{CLR, 32'h0,        32'h0,        32'h0,        1};
    tbl[1]  = '{MAC, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd32,       5};
    tbl[2]  = '{MAC, 32'hFFFFFFFF, 32'h0,        32'h0,        5};
    tbl[3]  = '{MAC, 32'h0000FFFF, 32'hFFFFFFFF, 32'h0,        5};
    tbl[4]  = '{RD,  32'h0,        32'h0,        32'h0,        1};
    tbl[5]  = '{MAC, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd32,       5};
    tbl[6]  = '{SGN, 32'd32,       32'h0,        32'd1,        1};
    tbl[7]  = '{RD,  32'h0,        32'h0,        32'h0,        1};
    tbl[8]  = '{MAC, 32'hFFFFFFFF, 32'h0,        32'hFFFFFFE0, 5};
    tbl[9]  = '{SGN, 32'h0,        32'h0,        32'h0,        1};
    tbl[10] = '{MAC, 32'hFFFFFFFF, 32'h0,        32'hFFFFFFE0, 5};
    tbl[11] = '{SGN, 32'h1234FFE0, 32'h0,        32'd1,        1};
    tbl[12] = '{MAC, 32'h0F0F0F0F, 32'h0,        32'h0,        5};
    tbl[13] = '{MAC, 32'h000000FF, 32'h0,        32'd16,       5};
    tbl[14] = '{RD,  32'h0,        32'h0,        32'd16,       1};
    tbl[15] = '{SGN, 32'h11,       32'h0,        32'h0,        1};
    tbl[16] = '{SGN, 32'h0,        32'h0,        32'd1,        1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    #1 check("req_ready_after_rst", {31'b0, req_ready}, 32'd1);

    foreach (tbl[i]) op(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat, $sformatf("tbl%0d_latency", i));

    // Saturation at both ends of the 16-bit accumulator
    op(CLR, 0, 0, 0, 1, "clr_latency");
    acc_m = 0;
    for (int i = 0; i < 1025; i++) begin
      acc_m = mac_m(acc_m, 32'hFFFFFFFF, 32'hFFFFFFFF);
      op(MAC, 32'hFFFFFFFF, 32'hFFFFFFFF, (i == 1024) ? 32'h00007FFF : 32'(acc_m), 5, "sat_hi_latency");
    end
    for (int i = 0; i < 2049; i++) begin
      acc_m = mac_m(acc_m, 32'hFFFFFFFF, 32'h0);
      op(MAC, 32'hFFFFFFFF, 32'h0, (i == 2048) ? 32'hFFFF8000 : 32'(acc_m), 5, "sat_lo_latency");
    end

    // Response back-pressure: data held, no new request accepted
    op(CLR, 0, 0, 0, 1, "clr_latency");
    resp_ready = 1'b0;
    issue(MAC, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'd32);
    do @(negedge clk); while (resp_valid !== 1'b1 && cyc - t_acc < 100);
    check("stall_latency", 32'(cyc - t_acc + 1), 32'd5);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_valid", {31'b0, resp_valid}, 32'd1);
      check("stall_data", resp_data, 32'd32);
      check("stall_req_ready", {31'b0, req_ready}, 32'd0);
      @(posedge clk);
    end
    #1 resp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;

    // clk_en low for two edges in the middle of COUNT stretches latency by two
    issue(MAC, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'd64);
    @(posedge clk); #1 clk_en = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 clk_en = 1'b1;
    wait_resp(7, "clk_en_latency");

    // Reset in the second COUNT cycle abandons the MAC
    issue(MAC, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_req_ready", {31'b0, req_ready}, 32'd0);
    check("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    #1 check("midrst_ready_after", {31'b0, req_ready}, 32'd1);
    begin
      int seen = 0;
      repeat (8) begin
        @(negedge clk);
        if (resp_valid !== 1'b0) seen++;
      end
      check("midrst_no_resp", 32'(seen), 32'd0);
    end
    op(RD, 0, 0, 0, 1, "read_after_rst_latency");

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bnn_acc_cfu.md
BNN_ACC_CFU -- requirements
Module: bnn_acc_cfu

Interface
REQ-001 SHALL have parameter CFU_LI_VERSION, default 0x01_00, meaning CFU-LI version, checked by check_cfu_l2_params.
REQ-002 SHALL have parameter CFU_N_CFUS, default 1, meaning number of CFUs (only 1 supported).
REQ-003 SHALL have parameter CFU_CFU_ID_W, default 0, meaning CFU id width.
REQ-004 SHALL have parameter CFU_FUNC_ID_W, default 2, meaning function id width.
REQ-005 SHALL have parameter CFU_DATA_W, default 32, meaning operand/result width; only 32 or 64 are legal.
REQ-006 SHALL have parameter ACC_W, default 16, meaning signed saturating accumulator width (2 <= ACC_W <= CFU_DATA_W).
REQ-007 SHALL have port clk, input, 1 bit, the single clock.
REQ-008 SHALL have port rst, input, 1 bit, reset that is synchronous and active-high.
REQ-009 SHALL have port clk_en, input, 1 bit; when 0, all state holds.
REQ-010 SHALL have port req_valid, input, 1 bit, request valid.
REQ-011 SHALL have port req_ready, output, 1 bit, request ready.
REQ-012 SHALL have port req_cfu, input, CFU_CFU_ID_W bits; it is ignored.
REQ-013 SHALL have port req_func, input, CFU_FUNC_ID_W bits, function id.
REQ-014 SHALL have port req_data0, input, CFU_DATA_W bits, operand a.
REQ-015 SHALL have port req_data1, input, CFU_DATA_W bits, operand b.
REQ-016 SHALL have port resp_valid, output, 1 bit, response valid.
REQ-017 SHALL have port resp_ready, input, 1 bit, response ready.
REQ-018 SHALL have port resp_status, output, CFU_STATUS_W bits; it is always CFU_OK.
REQ-019 SHALL have port resp_data, output, CFU_DATA_W bits, result.

Function
REQ-020 SHALL implement four functions:
- func 0 CLEAR: acc := 0, result 0.
- func 1 MAC: acc := sat(acc + 2*popcount(a ~^ b) - CFU_DATA_W), result is the new acc.
- func 2 READ: result is acc; acc is unchanged.
- func 3 SIGN: result is 1 if acc >= signed(a[ACC_W-1:0]), otherwise 0; acc := 0 afterwards.
REQ-021 SHALL have states IDLE, COUNT and RESP, with transitions:
- IDLE to COUNT on an accepted MAC.
- IDLE to RESP on any other accepted function.
- COUNT to RESP after N = CFU_DATA_W/8 COUNT cycles.
- RESP to IDLE on resp_valid && resp_ready.
REQ-022 SHALL drive req_ready = (state==IDLE) && !rst; a request is accepted on a clk_en cycle with req_valid && req_ready.
REQ-023 SHALL latch a, b and func on acceptance; later changes on req_* SHALL NOT affect the result.
REQ-024 In COUNT, SHALL add popcount of one 8-bit byte of (a ~^ b) per cycle, LSB byte first, into a partial count of log2(CFU_DATA_W)+1 bits.
REQ-025 SHALL update acc for a MAC at the clock edge that leaves COUNT.
REQ-026 With acceptance in cycle c0, SHALL first assert resp_valid in cycle c0+N+1 for MAC and in cycle c0+1 for other functions.
REQ-027 SHALL hold resp_valid, resp_data and resp_status stable while resp_ready=0; no new request is accepted in this interval.
REQ-028 SHALL allow a new request to be accepted, at the earliest, in the cycle after the response handshake.
REQ-029 SHALL saturate the MAC sum to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; it SHALL never wrap.
REQ-030 SHALL sign-extend acc-derived results from ACC_W to CFU_DATA_W; the SIGN result SHALL be zero-extended.
REQ-031 SHALL drive resp_data to 0 whenever resp_valid=0.
REQ-032 When clk_en=0, SHALL freeze state, COUNT progress and acc, and SHALL accept no handshake.

Reset
REQ-033 On rst=1 at a clock edge, SHALL set state to IDLE, acc to 0, the partial count to 0, resp_valid to 0, resp_data to 0 and resp_status to CFU_OK, regardless of clk_en.
REQ-034 Reset asserted during COUNT or RESP SHALL abandon the operation: no response is produced and acc is 0.
REQ-035 SHALL hold req_ready at 0 while rst=1 and SHALL set it to 1 in the first cycle after rst deasserts.

Verification
REQ-036 Bench SHALL apply CLEAR, then MAC a=b=0xFFFFFFFF accepted in c0 -> resp_valid in c0+5, resp_data=32.
REQ-037 Bench SHALL apply MAC a=0xFFFFFFFF, b=0 from acc=32 -> resp 0; then MAC a=0x0000FFFF, b=0xFFFFFFFF -> resp 0; then READ -> 0, one cycle after acceptance.
REQ-038 Bench SHALL apply 1025 MACs with a=b=0xFFFFFFFF from acc=0 (ACC_W=16) -> final resp 32767 (0x00007FFF); then 2049 MACs with a=0xFFFFFFFF, b=0 -> resp 0xFFFF8000.
REQ-039 Bench SHALL set acc=32 and apply SIGN a=32 -> 1, then READ -> 0; then set acc=-32 and apply SIGN a=0 -> 0.
REQ-040 Bench SHALL hold resp_ready=0 for 3 cycles after resp_valid on a MAC -> resp_data stable, req_ready=0 throughout; toggling clk_en=0 mid-COUNT for 2 cycles -> latency extended by exactly 2 cycles.
REQ-041 Bench SHALL assert rst in the 2nd COUNT cycle of a MAC -> no resp_valid, READ afterwards -> 0, req_ready=1 in the first cycle after rst deasserts.
